// File: rtl/avalon_slave_mem_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the avalon_slave_mem responder: FSM states,
// bus field widths, wait-state range limiting and address decode helpers.
package avalon_slave_mem_pkg;

    localparam int AV_ADDR_W = 32;
    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;
    localparam int WS_MAX    = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_AV_BUSY  = 2'd1,
        ST_AV_DONE  = 2'd2,
        ST_LOC_DONE = 2'd3
    } state_e;

    // Limits a requested wait-state count to what the 4-bit counter can hold.
    function automatic int wait_states_clamp(input int ws);
        if (ws < 0) begin
            return 0;
        end else if (ws > WS_MAX) begin
            return WS_MAX;
        end else begin
            return ws;
        end
    endfunction

    // Byte offset of an address from the window base; wraps for addresses below it.
    function automatic logic [AV_ADDR_W-1:0] window_offset(
        input logic [AV_ADDR_W-1:0] byte_addr,
        input logic [AV_ADDR_W-1:0] base_addr
    );
        return byte_addr - base_addr;
    endfunction

    // True when a window offset falls inside a span of span_bytes bytes.
    function automatic logic offset_in_range(
        input logic [AV_ADDR_W-1:0] offset,
        input logic [AV_ADDR_W-1:0] span_bytes
    );
        return (offset < span_bytes);
    endfunction

endpackage

// File: rtl/byte_en_ram.sv
`timescale 1ns/1ps
// Single-port DEPTH_WORDS x 32 RAM with synchronous read and per-byte write
// enables. Contents are deliberately not reset.
module byte_en_ram
    import avalon_slave_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [AV_BE_W-1:0]   be_i,
    input  logic [AV_DATA_W-1:0] wdata_i,
    output logic [AV_DATA_W-1:0] rdata_o
);

    logic [AV_DATA_W-1:0] mem_q [DEPTH_WORDS];

    // Byte-lane write plus registered read; a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < AV_BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/avalon_slave_mem.sv
`timescale 1ns/1ps
// Avalon-MM responder over an on-chip RAM shared with a local (DMA/loader)
// port; round-robin arbitration, wait states and a lock with idle timeout.
module avalon_slave_mem
    import avalon_slave_mem_pkg::*;
#(
    parameter int                   DEPTH_WORDS  = 1024,
    parameter logic [AV_ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int                   WAIT_STATES  = 1,
    parameter int                   LOCK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AV_ADDR_W-1:0] addr,
    input  logic [AV_BE_W-1:0]   byteenable,
    input  logic [AV_DATA_W-1:0] writedata,
    input  logic                 read,
    input  logic                 write,
    input  logic                 lock,
    output logic [AV_DATA_W-1:0] readdata,
    output logic                 waitrequest,
    input  logic                 loc_req,
    input  logic                 loc_we,
    input  logic [AV_ADDR_W-1:0] loc_addr,
    input  logic [AV_BE_W-1:0]   loc_be,
    input  logic [AV_DATA_W-1:0] loc_wdata,
    output logic                 loc_ack,
    output logic [AV_DATA_W-1:0] loc_rdata,
    output logic                 lock_held
);

    localparam int                   AW      = $clog2(DEPTH_WORDS);
    localparam int                   WS      = wait_states_clamp(WAIT_STATES);
    localparam int                   TW      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [AV_ADDR_W-1:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]           WS_LOAD = 4'((WS > 0) ? (WS - 1) : 0);
    localparam logic                 NO_WAIT = (WS == 0);
    localparam logic [TW-1:0]        TO_LAST = TW'(LOCK_TIMEOUT - 1);

    state_e               state_q;
    logic [3:0]           wait_cnt_q;
    logic [TW-1:0]        idle_cnt_q;
    logic                 last_loc_q;     // 1 when the local port won the last grant
    logic                 lock_held_q;
    logic                 lock_block_q;   // lock ignored until seen low after a timeout
    logic                 cmd_write_q;
    logic                 cmd_lock_q;
    logic                 in_range_q;
    logic [AW-1:0]        addr_q;
    logic [AV_BE_W-1:0]   be_q;
    logic [AV_DATA_W-1:0] wdata_q;
    logic                 waitrequest_q;
    logic                 loc_ack_q;

    logic                 av_req_s;
    logic                 loc_req_s;
    logic                 grant_av_s;
    logic                 grant_loc_s;
    logic [AV_ADDR_W-1:0] req_addr_s;
    logic [AV_ADDR_W-1:0] offset_s;
    logic                 in_range_s;
    logic [AW-1:0]        ram_addr_s;
    logic                 ram_we_s;
    logic [AV_DATA_W-1:0] ram_rdata_s;

    // Arbitration and RAM address/write-enable selection.
    always_comb begin
        av_req_s    = read | write;
        loc_req_s   = loc_req & ~lock_held_q;
        grant_av_s  = 1'b0;
        grant_loc_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (av_req_s && loc_req_s) begin
                grant_av_s  = last_loc_q;
                grant_loc_s = ~last_loc_q;
            end else begin
                grant_av_s  = av_req_s;
                grant_loc_s = loc_req_s;
            end
        end else begin
            grant_av_s  = 1'b0;
            grant_loc_s = 1'b0;
        end

        req_addr_s = grant_loc_s ? loc_addr : addr;
        offset_s   = window_offset(req_addr_s, BASE_ADDR);
        in_range_s = offset_in_range(offset_s, SPAN);

        // The RAM reads the live address on the grant cycle so its registered
        // output is ready for AV_DONE even with zero wait states.
        if (state_q == ST_IDLE) begin
            ram_addr_s = offset_s[AW+1:2];
        end else begin
            ram_addr_s = addr_q;
        end

        ram_we_s = ((state_q == ST_AV_DONE) || (state_q == ST_LOC_DONE)) &&
                   cmd_write_q && in_range_q;
    end

    // Access FSM with registered handshake outputs and lock bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 4'd0;
            idle_cnt_q    <= '0;
            last_loc_q    <= 1'b1;
            lock_held_q   <= 1'b0;
            lock_block_q  <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_lock_q    <= 1'b0;
            in_range_q    <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            waitrequest_q <= 1'b1;
            loc_ack_q     <= 1'b0;
        end else begin
            if (!lock) begin
                lock_block_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_av_s) begin
                        cmd_write_q <= write;
                        cmd_lock_q  <= lock & ~lock_block_q;
                        in_range_q  <= in_range_s;
                        addr_q      <= offset_s[AW+1:2];
                        be_q        <= byteenable;
                        wdata_q     <= writedata;
                        last_loc_q  <= 1'b0;
                        idle_cnt_q  <= '0;
                        if (NO_WAIT) begin
                            state_q       <= ST_AV_DONE;
                            waitrequest_q <= 1'b0;
                        end else begin
                            state_q    <= ST_AV_BUSY;
                            wait_cnt_q <= WS_LOAD;
                        end
                    end else if (grant_loc_s) begin
                        cmd_write_q <= loc_we;
                        cmd_lock_q  <= 1'b0;
                        in_range_q  <= in_range_s;
                        addr_q      <= offset_s[AW+1:2];
                        be_q        <= loc_be;
                        wdata_q     <= loc_wdata;
                        last_loc_q  <= 1'b1;
                        state_q     <= ST_LOC_DONE;
                        loc_ack_q   <= 1'b1;
                    end

                    if (lock_held_q && !av_req_s) begin
                        if (!lock) begin
                            lock_held_q <= 1'b0;
                            idle_cnt_q  <= '0;
                        end else if (idle_cnt_q == TO_LAST) begin
                            lock_held_q  <= 1'b0;
                            lock_block_q <= 1'b1;
                            idle_cnt_q   <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + TW'(1);
                        end
                    end
                end

                ST_AV_BUSY: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q       <= ST_AV_DONE;
                        waitrequest_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end

                ST_AV_DONE: begin
                    waitrequest_q <= 1'b1;
                    state_q       <= ST_IDLE;
                    if (cmd_lock_q) begin
                        lock_held_q <= 1'b1;
                    end
                end

                ST_LOC_DONE: begin
                    loc_ack_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q       <= ST_IDLE;
                    waitrequest_q <= 1'b1;
                    loc_ack_q     <= 1'b0;
                end
            endcase
        end
    end

    byte_en_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_s)
    );

    // Read data comes straight off the RAM output register, forced to zero
    // outside the completing cycle and for out-of-window addresses.
    assign readdata    = ((state_q == ST_AV_DONE) && in_range_q)  ? ram_rdata_s : 32'h0000_0000;
    assign loc_rdata   = ((state_q == ST_LOC_DONE) && in_range_q) ? ram_rdata_s : 32'h0000_0000;
    assign waitrequest = waitrequest_q;
    assign loc_ack     = loc_ack_q;
    assign lock_held   = lock_held_q;

endmodule

// File: tb/tb_avalon_slave_mem.sv
`timescale 1ns/1ps
// Self-checking bench for avalon_slave_mem: directed steps plus randomized
// traffic checked against a word-array memory model and a grant-order model.
module tb_avalon_slave_mem;

    localparam int DEPTH  = 1024;
    localparam int SPAN_B = DEPTH * 4;
    localparam int BOUND  = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] writedata = 32'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        lock = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        loc_req = 1'b0;
    logic        loc_we = 1'b0;
    logic [31:0] loc_addr = 32'h0;
    logic [3:0]  loc_be = 4'h0;
    logic [31:0] loc_wdata = 32'h0;
    logic        loc_ack;
    logic [31:0] loc_rdata;
    logic        lock_held;

    always #5 clk = ~clk;

    avalon_slave_mem #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (1),
        .LOCK_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .byteenable (byteenable),
        .writedata  (writedata),
        .read       (read),
        .write      (write),
        .lock       (lock),
        .readdata   (readdata),
        .waitrequest(waitrequest),
        .loc_req    (loc_req),
        .loc_we     (loc_we),
        .loc_addr   (loc_addr),
        .loc_be     (loc_be),
        .loc_wdata  (loc_wdata),
        .loc_ack    (loc_ack),
        .loc_rdata  (loc_rdata),
        .lock_held  (lock_held)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        return (a < 32'(SPAN_B));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'h0;
        return model[a[11:2]];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        if (model_hit(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // Entered just after a rising edge; returns just after the edge ending the access.
    task automatic av_access(input logic wr, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d, input logic lk,
                             output logic [31:0] rd, output int lat);
        read = ~wr; write = wr; addr = a; byteenable = be; writedata = d; lock = lk;
        lat = -1; rd = 32'h0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (!waitrequest) begin rd = readdata; lat = c; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        if (wr && lat >= 0) model_write(a, be, d);
    endtask

    task automatic loc_access(input logic wr, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d, output logic [31:0] rd, output int lat);
        loc_req = 1'b1; loc_we = wr; loc_addr = a; loc_be = be; loc_wdata = d;
        lat = -1; rd = 32'h0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (loc_ack) begin rd = loc_rdata; lat = c; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        loc_req = 1'b0;
        if (wr && lat >= 0) model_write(a, be, d);
    endtask

    task automatic av_check(input string tag, input logic wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d, input logic lk);
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        exp = model_read(a);
        av_access(wr, a, be, d, lk, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        if (!wr) check({tag, "_data"}, rd, exp);
    endtask

    task automatic loc_check(input string tag, input logic wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d);
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        exp = model_read(a);
        loc_access(wr, a, be, d, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        if (!wr) check({tag, "_data"}, rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cd_av [4];
        logic [31:0] cd_loc [4];
        int          exp_q [$];
        int          got_q [$];
        int          a_left, l_left, av_k, loc_k, got_v;
        logic        last_loc;
        logic [31:0] ra, rdat;
        logic [3:0]  rbe;
        int          op, lat, fall_c, ack_c;
        logic        saw_ack;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", waitrequest, 32'd1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_loc_ack", loc_ack, 32'd0);
        check("rst_loc_rdata", loc_rdata, 32'h0);
        check("rst_lock_held", lock_held, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_waitrequest", waitrequest, 32'd1);
        @(posedge clk); #1;

        // Contention: both sides hold requests for four writes each
        for (int i = 0; i < 4; i++) begin cd_av[i] = $urandom; cd_loc[i] = $urandom; end
        a_left = 4; l_left = 4; last_loc = 1'b1;
        while (a_left > 0 || l_left > 0) begin
            if (a_left > 0 && (l_left == 0 || last_loc)) begin
                exp_q.push_back(0); a_left--; last_loc = 1'b0;
            end else begin
                exp_q.push_back(1); l_left--; last_loc = 1'b1;
            end
        end
        av_k = 0; loc_k = 0;
        write = 1'b1; read = 1'b0; lock = 1'b0; byteenable = 4'hF;
        addr = 32'h100; writedata = cd_av[0];
        loc_req = 1'b1; loc_we = 1'b1; loc_be = 4'hF; loc_addr = 32'h200; loc_wdata = cd_loc[0];
        for (int c = 0; c < BOUND && (av_k < 4 || loc_k < 4); c++) begin
            @(negedge clk);
            if (!waitrequest) begin got_q.push_back(0); model_write(addr, byteenable, writedata); av_k++; end
            if (loc_ack) begin got_q.push_back(1); model_write(loc_addr, loc_be, loc_wdata); loc_k++; end
            @(posedge clk); #1;
            write = (av_k < 4);
            addr = 32'h100 + 32'(av_k * 4); writedata = cd_av[av_k % 4];
            loc_req = (loc_k < 4);
            loc_addr = 32'h200 + 32'(loc_k * 4); loc_wdata = cd_loc[loc_k % 4];
        end
        write = 1'b0; loc_req = 1'b0;
        check("rr_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got_v = (i < got_q.size()) ? got_q[i] : 9;
            check($sformatf("rr_order_%0d", i), 32'(got_v), 32'(exp_q[i]));
        end
        for (int k = 0; k < 4; k++) begin
            av_check("rr_rd_loc", 1'b0, 32'h200 + 32'(k * 4), 4'hF, 32'h0, 1'b0);
            loc_check("rr_rd_av", 1'b0, 32'h100 + 32'(k * 4), 4'hF, 32'h0);
        end

        // Basic and partial writes
        av_check("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        av_check("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        av_check("wr14", 1'b1, 32'h14, 4'hF, 32'h11223344, 1'b0);
        av_check("wr14p", 1'b1, 32'h14, 4'b0001, 32'h000000AA, 1'b0);
        av_access(1'b0, 32'h14, 4'hF, 32'h0, 1'b0, rdat, lat);
        check("partial_data", rdat, 32'h112233AA);

        // Out-of-range read is acknowledged and returns zero
        av_check("oor_rd", 1'b0, 32'h0000_1010, 4'hF, 32'h0, 1'b0);
        av_check("oor_rd_hi", 1'b0, 32'hFFFF_FFF0, 4'hF, 32'h0, 1'b0);

        // Randomized traffic over a prefilled region
        for (int k = 0; k < 16; k++) loc_check("fill", 1'b1, 32'h300 + 32'(k * 4), 4'hF, $urandom);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) ra = 32'h1300 + 32'($urandom_range(0, 15)) * 32'd4;
            else                           ra = 32'h300 + 32'($urandom_range(0, 15)) * 32'd4;
            rdat = $urandom;
            rbe  = 4'($urandom_range(1, 15));
            case (op)
                0:       av_check("rnd_avw", 1'b1, ra, rbe, rdat, 1'b0);
                1:       av_check("rnd_avr", 1'b0, ra, rbe, rdat, 1'b0);
                2:       loc_check("rnd_lw", 1'b1, ra, rbe, rdat);
                default: loc_check("rnd_lr", 1'b0, ra, rbe, rdat);
            endcase
        end
        for (int k = 0; k < 16; k++) av_check("rnd_final", 1'b0, 32'h300 + 32'(k * 4), 4'hF, 32'h0, 1'b0);

        // Lock excludes the local port until lock drops
        av_check("lk_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        check("lk_held_set", lock_held, 32'd1);
        @(posedge clk); #1;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 32'h10; loc_be = 4'hF;
        saw_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (loc_ack) saw_ack = 1'b1;
            @(posedge clk); #1;
        end
        check("lk_excl", saw_ack, 32'd0);
        @(negedge clk);
        check("lk_still_held", lock_held, 32'd1);
        @(posedge clk); #1;
        lock = 1'b0;
        lat = -1; rdat = 32'h0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (loc_ack) begin lat = c; rdat = loc_rdata; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        loc_req = 1'b0;
        check("lk_rel_lat", 32'(lat), 32'd2);
        check("lk_rel_data", rdat, model_read(32'h10));
        check("lk_released", lock_held, 32'd0);

        // Lock timeout with lock held high and a local write pending
        av_check("to_rd", 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 32'h18; loc_be = 4'hF; loc_wdata = $urandom;
        fall_c = -1; ack_c = -1;
        for (int c = 0; c < BOUND && ack_c < 0; c++) begin
            @(negedge clk);
            if (fall_c < 0 && !lock_held) fall_c = c;
            if (loc_ack) ack_c = c;
            @(posedge clk); #1;
        end
        loc_req = 1'b0;
        if (ack_c >= 0) model_write(loc_addr, loc_be, loc_wdata);
        check("to_fall_window", 32'(fall_c >= 63 && fall_c <= 65), 32'd1);
        check("to_ack_after_fall", 32'(ack_c - fall_c), 32'd1);
        av_check("to_ignored", 1'b0, 32'h18, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        check("to_lock_ignored", lock_held, 32'd0);
        @(posedge clk); #1;
        av_check("to_unlk", 1'b0, 32'h18, 4'hF, 32'h0, 1'b0);
        av_check("to_relock", 1'b0, 32'h18, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        check("to_relock_held", lock_held, 32'd1);
        @(posedge clk); #1;
        lock = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("to_relock_rel", lock_held, 32'd0);
        @(posedge clk); #1;

        // Reset during AV_BUSY aborts the write
        av_check("rs_pre", 1'b1, 32'h40, 4'hF, 32'hCAFE0040, 1'b0);
        write = 1'b1; addr = 32'h40; byteenable = 4'hF; writedata = 32'h5555AAAA;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("rs_busy_wait", waitrequest, 32'd1);
        write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        av_check("rs_busy_rd", 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);

        // Reset during AV_DONE, before the commit edge, also drops the write
        av_check("rs2_pre", 1'b1, 32'h44, 4'hF, 32'hFEED0044, 1'b0);
        write = 1'b1; addr = 32'h44; byteenable = 4'hF; writedata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rs2_done_low", waitrequest, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rs2_wait_async", waitrequest, 32'd1);
        check("rs2_rdata_async", readdata, 32'h0);
        write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        av_check("rs2_rd", 1'b0, 32'h44, 4'hF, 32'h0, 1'b0);
        av_check("rs_other", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_slave_mem.md
# avalon_slave_mem

Avalon-MM responder backed by a word-addressed on-chip RAM: the slave-side counterpart of the core's Avalon bus master. It serves the master's read, write and locked (LR/SC/AMO) sequences with a programmable number of wait states. A second local port, used by a DMA or testbench loader, shares the RAM. Arbitration is round-robin, and the Avalon `lock` excludes the local port.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; must be a power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte base address; must be aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, default 1: extra cycles `waitrequest` stays high per Avalon access; range 0–15.
- `LOCK_TIMEOUT`, default 64: idle cycles after which a held lock is forcibly released.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, active-low, asynchronous.
- `addr` in 32: Avalon byte address; bits [1:0] are ignored.
- `byteenable` in 4: write byte lanes.
- `writedata` in 32: write data.
- `read` in 1: read request, held by the master until `waitrequest` is low.
- `write` in 1: write request, held by the master until `waitrequest` is low.
- `lock` in 1: the master requests exclusive access.
- `readdata` out 32: valid in the cycle `waitrequest` is low for a read.
- `waitrequest` out 1: low for exactly the completing cycle of an access.
- `loc_req` in 1: local access request, level, held until `loc_ack`.
- `loc_we` in 1: local write when 1, read when 0.
- `loc_addr` in 32: local byte address.
- `loc_be` in 4: local byte enables.
- `loc_wdata` in 32: local write data.
- `loc_ack` out 1: one-cycle completion pulse.
- `loc_rdata` out 32: valid while `loc_ack` is high.
- `lock_held` out 1: the Avalon master currently owns the RAM.

## Operation
States: IDLE, AV_BUSY, AV_DONE, LOC_DONE.

- **IDLE arbitration:**
  - Avalon request = `read|write`. Local request = `loc_req & ~lock_held`.
  - If only one is present, grant it. If both are present, grant the side not granted last (`last_grant` bit; Avalon first after reset).
  - Avalon grant goes to AV_BUSY, or directly to AV_DONE when `WAIT_STATES`==0.
  - Local grant goes to LOC_DONE.
- **AV_BUSY:** the counter runs from `WAIT_STATES-1` down to 0, then the state moves to AV_DONE. Address, data and command are sampled once, on grant.
- **AV_DONE:**
  - `waitrequest`=0 and `readdata` is driven from the registered RAM output.
  - A write commits the enabled bytes at the end of this cycle.
  - If the sampled `lock`=1, set `lock_held`.
  - Next state is IDLE.
- **LOC_DONE:** `loc_ack`=1. A local write commits at the end of this cycle. Next state is IDLE.
- **Address decode:** in range when `addr - BASE_ADDR < DEPTH_WORDS*4`. Out-of-range reads return 0; out-of-range writes are dropped. Both are still acknowledged normally.
- **Lock release:** `lock_held` clears in IDLE when `lock`=0 and there is no Avalon request.
- **Lock timeout:** an idle counter runs while `lock_held` is set in IDLE. At `LOCK_TIMEOUT` consecutive idle cycles, `lock_held` clears and `lock` is then ignored until it is seen low once. Any Avalon access resets the counter.
- **Write-then-read:** a read always returns data including an immediately preceding write; the write commits before the next grant.

## Timing
- Avalon access: cycle 0 is the first IDLE cycle with `read|write` high. `waitrequest` is high in cycles 0..`WAIT_STATES` and low in cycle `WAIT_STATES+1`. Total latency is `WAIT_STATES+2` cycles.
- `waitrequest` is high whenever the state is not AV_DONE, including with no request present.
- Back-to-back Avalon accesses: the next access is granted in the cycle after AV_DONE.
- Local access: grant in cycle 0, `loc_ack` in cycle 1. A local request arriving while `lock_held` waits indefinitely, or until the timeout.
- Reset values:
  - State IDLE.
  - `waitrequest`=1, `readdata`=0.
  - `loc_ack`=0, `loc_rdata`=0.
  - `lock_held`=0, `last_grant`=local (so Avalon wins first).
  - All counters 0.
- RAM contents are not reset.
- Reset mid-access aborts the access. A pending write is not committed unless its commit edge has already passed.

## Structure
- Shared package: the state enum and the `WAIT_STATES` range check. The Avalon field widths (32 address/data, 4 byteenable) belong in the existing bus package.
- One sub-module, `byte_en_ram`: a single-port RAM with synchronous read and byte-enable write, `DEPTH_WORDS`×32.

## Test plan
- **Basic read/write, `WAIT_STATES`=1:** write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10. `waitrequest` is low in cycle 2 of each access and `readdata`=32'hDEADBEEF.
- **Partial write:** write 32'h000000AA with be=4'b0001 over 0x11223344, then read. Result is 32'h112233AA.
- **Simultaneous requests:** Avalon and local requests in the same cycle, repeated 4 times. Grants alternate A, L, A, L, and neither side starves.
- **Lock:** Avalon read with `lock`=1, then `loc_req` asserted. `loc_ack` stays 0 until `lock` drops. After release, `loc_ack` arrives in 2 cycles.
- **Lock timeout:** `lock` held with no traffic, `LOCK_TIMEOUT`=64. `lock_held` falls after cycle 64 and the pending local access completes.
- **Boundaries:** out-of-range read returns 0 with a normal ack. Async reset asserted in AV_BUSY gives `waitrequest`=1 immediately, and the RAM is unchanged.
